// File: rtl/regfile_writeback_arbiter.sv
// Write-side front end of the 32 x XLEN register file: arbitrates ALU and load results
// onto a single registered write port and tracks destinations with writes in flight.
module regfile_writeback_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            wrt_high_enable,
    output logic [4:0]      destn_reg,
    output logic [XLEN-1:0] destn_data,
    output logic [31:0]     busy_mask
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]      starve_q, starve_d;
    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [31:0]     busy_q, busy_d;

    logic            force_alu_s;
    logic            alu_fire_s;
    logic            mem_fire_s;
    logic            fire_s;
    logic [4:0]      win_rd_s;
    logic [XLEN-1:0] win_data_s;

    // Loads win by default; the ALU wins when idle loads allow it or when it has starved.
    always_comb begin
        force_alu_s = alu_valid && (starve_q == LIMIT);
        mem_ready   = !force_alu_s;
        alu_ready   = !mem_valid || force_alu_s;
        alu_fire_s  = alu_valid && alu_ready;
        mem_fire_s  = mem_valid && mem_ready;
        fire_s      = alu_fire_s || mem_fire_s;
        if (alu_fire_s) begin
            win_rd_s   = alu_rd;
            win_data_s = alu_data;
        end else begin
            win_rd_s   = mem_rd;
            win_data_s = mem_data;
        end
    end

    // Next-state for starve counter, write port and busy scoreboard.
    always_comb begin
        starve_d = starve_q;
        we_d     = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        busy_d   = busy_q;

        if (alu_fire_s || !alu_valid) begin
            starve_d = 4'd0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = LIMIT;
        end

        // Writes to x0 are consumed but never reach the register file.
        if (fire_s && (win_rd_s != 5'd0)) begin
            we_d             = 1'b1;
            rd_d             = win_rd_s;
            data_d           = win_data_s;
            busy_d[win_rd_s] = 1'b0;
        end else begin
            we_d = 1'b0;
        end

        // Applied after the clear so a same-index issue keeps the bit set.
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset; transfers in the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'd0;
            we_q     <= 1'b0;
            rd_q     <= 5'd0;
            data_q   <= '0;
            busy_q   <= 32'd0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign wrt_high_enable = we_q;
    assign destn_reg       = rd_q;
    assign destn_data      = data_q;
    assign busy_mask       = busy_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed self-checking bench for regfile_writeback_arbiter.
module tb_regfile_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wrt_high_enable;
    logic [4:0]  destn_reg;
    logic [63:0] destn_data;
    logic [31:0] busy_mask;

    int n_checks;
    int n_fail;

    regfile_writeback_arbiter #(.XLEN(64), .STARVE_LIMIT(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .wrt_high_enable (wrt_high_enable),
        .destn_reg       (destn_reg),
        .destn_data      (destn_data),
        .busy_mask       (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        alu_rd      = 5'd0;
        mem_rd      = 5'd0;
        issue_rd    = 5'd0;
        alu_data    = 64'd0;
        mem_data    = 64'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();

        // Reset with traffic present: everything dropped.
        reset       = 1'b1;
        alu_valid   = 1'b1;
        alu_rd      = 5'd3;
        alu_data    = 64'h1234;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        check_eq("rst_we",   {63'd0, wrt_high_enable}, 64'd0);
        check_eq("rst_busy", {32'd0, busy_mask}, 64'd0);
        check_eq("rst_data", destn_data, 64'd0);
        check_eq("rst_reg",  {59'd0, destn_reg}, 64'd0);
        reset = 1'b0;
        idle();
        tick();
        check_eq("idle_we", {63'd0, wrt_high_enable}, 64'd0);

        // Single ALU write, one-cycle pulse.
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 64'hDEAD_BEEF;
        #1;
        check_eq("alu_ready", {63'd0, alu_ready}, 64'd1);
        tick();
        check_eq("alu_we",   {63'd0, wrt_high_enable}, 64'd1);
        check_eq("alu_reg",  {59'd0, destn_reg}, 64'd5);
        check_eq("alu_data", destn_data, 64'hDEAD_BEEF);
        idle();
        tick();
        check_eq("alu_we_drop",   {63'd0, wrt_high_enable}, 64'd0);
        check_eq("alu_reg_hold",  {59'd0, destn_reg}, 64'd5);
        check_eq("alu_data_hold", destn_data, 64'hDEAD_BEEF);

        // Contention: pattern M,M,M,A twice.
        alu_valid = 1'b1;
        alu_rd    = 5'd10;
        alu_data  = 64'hAAAA;
        mem_valid = 1'b1;
        mem_rd    = 5'd11;
        mem_data  = 64'hBBBB;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("cont_mem_rdy", {63'd0, mem_ready}, (i % 4 == 3) ? 64'd0 : 64'd1);
            check_eq("cont_alu_rdy", {63'd0, alu_ready}, (i % 4 == 3) ? 64'd1 : 64'd0);
            tick();
            check_eq("cont_we",  {63'd0, wrt_high_enable}, 64'd1);
            check_eq("cont_reg", {59'd0, destn_reg}, (i % 4 == 3) ? 64'd10 : 64'd11);
        end
        idle();

        // x0 write accepted but not performed; x0 issue ignored.
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 64'd1;
        #1;
        check_eq("x0_mem_rdy", {63'd0, mem_ready}, 64'd1);
        tick();
        check_eq("x0_we",   {63'd0, wrt_high_enable}, 64'd0);
        check_eq("x0_reg",  {59'd0, destn_reg}, 64'd10);
        check_eq("x0_data", destn_data, 64'hAAAA);
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        tick();
        check_eq("x0_busy", {32'd0, busy_mask}, 64'd0);

        // Scoreboard set, set-wins collision, then clear.
        issue_rd = 5'd7;
        tick();
        check_eq("sb_set", {32'd0, busy_mask}, 64'h80);
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 64'd77;
        tick();
        check_eq("sb_collide", {32'd0, busy_mask}, 64'h80);
        check_eq("sb_col_reg", {59'd0, destn_reg}, 64'd7);
        issue_valid = 1'b0;
        alu_data    = 64'd78;
        tick();
        check_eq("sb_clear", {32'd0, busy_mask}, 64'd0);
        check_eq("sb_data",  destn_data, 64'd78);
        idle();

        // Back-to-back loads to x1..x4.
        mem_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mem_rd   = 5'(i);
            mem_data = 64'(100 + i);
            tick();
            check_eq("b2b_we",   {63'd0, wrt_high_enable}, 64'd1);
            check_eq("b2b_reg",  {59'd0, destn_reg}, 64'(i));
            check_eq("b2b_data", destn_data, 64'(100 + i));
        end
        idle();
        tick();
        check_eq("b2b_end_we", {63'd0, wrt_high_enable}, 64'd0);

        // Write to a non-busy register still lands and leaves the mask clear.
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        tick();
        check_eq("busy12", {32'd0, busy_mask}, 64'h1000);
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_rd      = 5'd20;
        alu_data    = 64'h55;
        tick();
        check_eq("nb_we",   {63'd0, wrt_high_enable}, 64'd1);
        check_eq("nb_busy", {32'd0, busy_mask}, 64'h1000);

        // Reset mid-traffic clears busy bits and drops the transfer.
        reset    = 1'b1;
        alu_rd   = 5'd9;
        alu_data = 64'h99;
        tick();
        reset = 1'b0;
        idle();
        check_eq("rst2_we",   {63'd0, wrt_high_enable}, 64'd0);
        check_eq("rst2_busy", {32'd0, busy_mask}, 64'd0);
        check_eq("rst2_data", destn_data, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
